// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFill   = 3'd1,
    StHold   = 3'd2,
    StTiming = 3'd3,
    StDone   = 3'd4
  } f1_state_t;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances on every clock.
module lfsr16
  import f1_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1  // must be non-zero
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value of the shift register.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills the bar one light per tick, holds for a
// pseudo-random number of ticks, then times the driver's reaction.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int unsigned N_LIGHTS  = 8,
  parameter int unsigned MIN_HOLD  = 2,
  parameter int unsigned HOLD_W    = 3,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                trigger,
  input  logic                react,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                lights_out,
  output logic                result_valid,
  output logic                jump_start,
  output logic [CNT_W-1:0]    react_time
);

  // Wide enough for MIN_HOLD + (2**HOLD_W - 1).
  localparam int unsigned HOLD_CW = $clog2(MIN_HOLD + (1 << HOLD_W));

  f1_state_t state_q, state_d;

  logic [N_LIGHTS-1:0] bar_q, bar_d;
  logic [HOLD_CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    react_time_q, react_time_d;
  logic                result_valid_q, result_valid_d;
  logic                jump_start_q, jump_start_d;
  logic                lights_out_q, lights_out_d;
  logic                trigger_prev_q;
  logic                react_prev_q;

  logic [15:0]         lfsr_q;
  logic                trig_rise;
  logic                react_rise;
  logic [N_LIGHTS:0]   bar_ext;
  logic [N_LIGHTS-1:0] bar_shift;
  logic [HOLD_CW-1:0]  hold_load;
  logic [CNT_W-1:0]    rt_inc;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Only the low HOLD_W bits feed the hold length.
  if (HOLD_W < 16) begin : g_lfsr_unused
    logic lfsr_unused;
    assign lfsr_unused = ^lfsr_q[15:HOLD_W];
  end

  // Edge detection against the previous-cycle sample; helper datapath values.
  always_comb begin
    trig_rise  = trigger & ~trigger_prev_q;
    react_rise = react & ~react_prev_q;
    // Shift in a one at bit 0; the extended form keeps N_LIGHTS == 1 legal.
    bar_ext    = {bar_q, 1'b1};
    bar_shift  = bar_ext[N_LIGHTS-1:0];
    hold_load  = HOLD_CW'(MIN_HOLD) + HOLD_CW'(lfsr_q[HOLD_W-1:0]);
    // Reaction counter saturates at all ones.
    rt_inc     = (&react_time_q) ? react_time_q : react_time_q + CNT_W'(1);
  end

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d        = state_q;
    bar_d          = bar_q;
    hold_cnt_d     = hold_cnt_q;
    react_time_d   = react_time_q;
    result_valid_d = result_valid_q;
    jump_start_d   = jump_start_q;
    lights_out_d   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // Results stay on display until a fresh start.
        if (trig_rise) begin
          state_d        = StFill;
          bar_d          = '0;
          hold_cnt_d     = '0;
          react_time_d   = '0;
          result_valid_d = 1'b0;
          jump_start_d   = 1'b0;
        end
      end

      StFill: begin
        if (react_rise) begin
          state_d        = StDone;
          bar_d          = '0;
          hold_cnt_d     = '0;
          react_time_d   = '0;
          result_valid_d = 1'b0;
          jump_start_d   = 1'b1;
        end else if (tick) begin
          bar_d = bar_shift;
          if (&bar_shift) begin
            hold_cnt_d = hold_load;
            state_d    = StHold;
          end
        end
      end

      StHold: begin
        // A react on the final hold tick still counts as a jump start.
        if (react_rise) begin
          state_d        = StDone;
          bar_d          = '0;
          hold_cnt_d     = '0;
          react_time_d   = '0;
          result_valid_d = 1'b0;
          jump_start_d   = 1'b1;
        end else if (tick) begin
          // A zero hold (MIN_HOLD == 0) exits on the first tick too.
          if (hold_cnt_q <= HOLD_CW'(1)) begin
            hold_cnt_d   = '0;
            bar_d        = '0;
            lights_out_d = 1'b1;
            state_d      = StTiming;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_CW'(1);
          end
        end
      end

      StTiming: begin
        // Counts every clock; a react edge here lands as count + 1.
        react_time_d = rt_inc;
        if (react_rise || (&rt_inc)) begin
          state_d        = StDone;
          result_valid_d = 1'b1;
        end
      end

      default: begin
        state_d        = StIdle;
        bar_d          = '0;
        hold_cnt_d     = '0;
        react_time_d   = '0;
        result_valid_d = 1'b0;
        jump_start_d   = 1'b0;
      end
    endcase
  end

  // Sequencer state and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      bar_q          <= '0;
      hold_cnt_q     <= '0;
      react_time_q   <= '0;
      result_valid_q <= 1'b0;
      jump_start_q   <= 1'b0;
      lights_out_q   <= 1'b0;
      trigger_prev_q <= 1'b0;
      react_prev_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bar_q          <= bar_d;
      hold_cnt_q     <= hold_cnt_d;
      react_time_q   <= react_time_d;
      result_valid_q <= result_valid_d;
      jump_start_q   <= jump_start_d;
      lights_out_q   <= lights_out_d;
      trigger_prev_q <= trigger;
      react_prev_q   <= react;
    end
  end

  // Output mapping.
  always_comb begin
    data_out     = bar_q;
    busy         = (state_q == StFill) || (state_q == StHold) || (state_q == StTiming);
    lights_out   = lights_out_q;
    result_valid = result_valid_q;
    jump_start   = jump_start_q;
    react_time   = react_time_q;
  end

endmodule

// File: tb/tb_f1_light_seq.sv
// Scoreboard bench for f1_light_seq: two instances (CNT_W 16 and 4) share
// stimulus; a monitor pops expected events per instance as outputs change.
module tb_f1_light_seq;

  localparam int NL   = 8;
  localparam int MINH = 2;

  logic clk = 1'b0;
  logic rst_n, tick, trigger, react;

  logic [7:0]  data_out, data_out_s;
  logic        busy, busy_s, lights_out, lights_out_s;
  logic        rv, rv_s, js, js_s;
  logic [15:0] rt;
  logic [3:0]  rt_s;

  always #5 clk = ~clk;

  f1_light_seq #(
    .N_LIGHTS (8), .MIN_HOLD (2), .HOLD_W (3), .CNT_W (16), .LFSR_SEED (16'hACE1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .tick (tick), .trigger (trigger), .react (react),
    .data_out (data_out), .busy (busy), .lights_out (lights_out),
    .result_valid (rv), .jump_start (js), .react_time (rt)
  );

  f1_light_seq #(
    .N_LIGHTS (8), .MIN_HOLD (2), .HOLD_W (3), .CNT_W (4), .LFSR_SEED (16'hACE1)
  ) dut_s (
    .clk (clk), .rst_n (rst_n), .tick (tick), .trigger (trigger), .react (react),
    .data_out (data_out_s), .busy (busy_s), .lights_out (lights_out_s),
    .result_valid (rv_s), .jump_start (js_s), .react_time (rt_s)
  );

  typedef enum int {EvNone, EvBar, EvLo, EvDone} ev_t;
  typedef struct {
    ev_t kind;
    int  data;
    int  busy;
    int  rt;
    int  rv;
    int  js;
    int  stamp;  // expected tick count when the event shows; -1 = don't care
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks   = 0;
  int errors   = 0;
  int tick_cnt = 0;

  // Reference LFSR: x >> 1, xor 0xB400 when the bit shifted out was 1.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= (m_lfsr >> 1) ^ ({16{m_lfsr[0]}} & 16'hB400);
  end

  function automatic logic [15:0] adv(input logic [15:0] v, input int n);
    logic [15:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = (x >> 1) ^ ({16{x[0]}} & 16'hB400);
    return x;
  endfunction

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0d required=%0d t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic push(input int inst, input ev_t k, input int d, input int b, input int r,
                      input int v, input int j, input int s);
    exp_t e;
    e.kind = k; e.data = d; e.busy = b; e.rt = r; e.rv = v; e.js = j; e.stamp = s;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // Monitor: classify output changes per instance and compare with the queue head.
  int   mon_d, mon_rt;
  logic mon_lo, mon_b, mon_rv, mon_js, mon_have;
  int   prev_d[2];
  logic prev_done[2];
  ev_t  mon_kind;
  exp_t mon_e;

  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mon_d  = (i == 0) ? int'(data_out) : int'(data_out_s);
      mon_rt = (i == 0) ? int'(rt) : int'(rt_s);
      mon_lo = (i == 0) ? lights_out : lights_out_s;
      mon_b  = (i == 0) ? busy : busy_s;
      mon_rv = (i == 0) ? rv : rv_s;
      mon_js = (i == 0) ? js : js_s;
      if (!rst_n) begin
        prev_d[i]    = 0;
        prev_done[i] = 1'b0;
      end else begin
        if (mon_lo)                                mon_kind = EvLo;
        else if ((mon_rv | mon_js) && !prev_done[i]) mon_kind = EvDone;
        else if (mon_d != prev_d[i])               mon_kind = EvBar;
        else                                       mon_kind = EvNone;
        if (mon_kind != EvNone) begin
          mon_have = 1'b0;
          if (i == 0 && q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
          if (i == 1 && q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
          if (!mon_have) begin
            chk("event_expected", i, 0, 1);
          end else begin
            chk("ev_kind", i, int'(mon_kind), int'(mon_e.kind));
            chk("ev_data_out", i, mon_d, mon_e.data);
            chk("ev_busy", i, int'(mon_b), mon_e.busy);
            chk("ev_react_time", i, mon_rt, mon_e.rt);
            chk("ev_result_valid", i, int'(mon_rv), mon_e.rv);
            chk("ev_jump_start", i, int'(mon_js), mon_e.js);
            if (mon_e.stamp >= 0) chk("ev_tick_index", i, tick_cnt, mon_e.stamp);
          end
        end
        prev_d[i]    = mon_d;
        prev_done[i] = mon_rv | mon_js;
      end
    end
  end

  // One tick every 4 clocks; optional react edge on the same cycle.
  task automatic pulse_tick(input bit with_react, output logic [15:0] lf);
    repeat (3) @(negedge clk);
    tick = 1'b1;
    if (with_react) react = 1'b1;
    @(posedge clk);
    lf = m_lfsr;  // value the DUT samples on this edge
    tick_cnt++;
    @(negedge clk);
    tick  = 1'b0;
    react = 1'b0;
  endtask

  // Start a sequence and fill the bar; returns the expected hold length.
  task automatic fill(input bit mid_trig, output int hold);
    logic [15:0] lf;
    lf = '0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk("busy_after_trigger", 0, int'(busy), 1);
    chk("busy_after_trigger", 1, int'(busy_s), 1);
    chk("rv_cleared", 0, int'(rv), 0);
    chk("js_cleared", 0, int'(js), 0);
    chk("rt_cleared", 0, int'(rt), 0);
    chk("rt_cleared", 1, int'(rt_s), 0);
    for (int i = 1; i <= NL; i++) begin
      push(0, EvBar, (1 << i) - 1, 1, 0, 0, 0, tick_cnt + 1);
      push(1, EvBar, (1 << i) - 1, 1, 0, 0, 0, tick_cnt + 1);
      pulse_tick(1'b0, lf);
      if (mid_trig && i == 4) begin
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
      end
    end
    hold = MINH + int'(lf[2:0]);
  endtask

  // mode 0: react k clocks after lights-out; 1: react early in HOLD;
  // 2: react on the same cycle as the last HOLD tick.
  task automatic seq(input int mode, input int k);
    int hold, rt_b, rt_sm, exp_rv, exp_js;
    logic [15:0] lf;
    fill(mode == 0, hold);
    if (mode == 1) begin
      push(0, EvDone, 0, 0, 0, 0, 1, tick_cnt);
      push(1, EvDone, 0, 0, 0, 0, 1, tick_cnt);
      react = 1'b1;
      @(negedge clk);
      react = 1'b0;
    end else if (mode == 2) begin
      for (int h = 1; h < hold; h++) pulse_tick(1'b0, lf);
      push(0, EvDone, 0, 0, 0, 0, 1, tick_cnt + 1);
      push(1, EvDone, 0, 0, 0, 0, 1, tick_cnt + 1);
      pulse_tick(1'b1, lf);
    end else begin
      push(0, EvLo, 0, 1, 0, 0, 0, tick_cnt + hold);
      push(1, EvLo, 0, 1, 0, 0, 0, tick_cnt + hold);
      for (int h = 1; h <= hold; h++) pulse_tick(1'b0, lf);
      // Now in the first TIMING cycle.
      push(0, EvDone, 0, 0, k, 1, 0, -1);
      push(1, EvDone, 0, 0, (k < 15) ? k : 15, 1, 0, -1);
      repeat (k - 1) @(negedge clk);
      react = 1'b1;
      @(negedge clk);
      react = 1'b0;
    end
    // Results must hold in DONE, with ticks ignored.
    repeat (3) @(negedge clk);
    pulse_tick(1'b0, lf);
    pulse_tick(1'b0, lf);
    rt_b   = (mode == 0) ? k : 0;
    rt_sm  = (mode == 0) ? ((k < 15) ? k : 15) : 0;
    exp_rv = (mode == 0) ? 1 : 0;
    exp_js = (mode == 0) ? 0 : 1;
    chk("held_react_time", 0, int'(rt), rt_b);
    chk("held_react_time", 1, int'(rt_s), rt_sm);
    chk("held_result_valid", 0, int'(rv), exp_rv);
    chk("held_jump_start", 0, int'(js), exp_js);
    chk("held_busy", 0, int'(busy), 0);
    chk("held_data_out", 0, int'(data_out), 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_data_out"}, 0, int'(data_out), 0);
    chk({nm, "_data_out"}, 1, int'(data_out_s), 0);
    chk({nm, "_busy"}, 0, int'(busy), 0);
    chk({nm, "_busy"}, 1, int'(busy_s), 0);
    chk({nm, "_lights_out"}, 0, int'(lights_out), 0);
    chk({nm, "_flags"}, 0, int'({rv, js}), 0);
    chk({nm, "_react_time"}, 0, int'(rt), 0);
    chk({nm, "_react_time"}, 1, int'(rt_s), 0);
  endtask

  // Abort mid-HOLD (where 0) or mid-TIMING (where 1) with an async reset.
  task automatic reset_mid(input int where);
    int hold;
    logic [15:0] lf;
    fill(1'b0, hold);
    if (where == 0) begin
      pulse_tick(1'b0, lf);
    end else begin
      push(0, EvLo, 0, 1, 0, 0, 0, tick_cnt + hold);
      push(1, EvLo, 0, 1, 0, 0, 0, tick_cnt + hold);
      for (int h = 1; h <= hold; h++) pulse_tick(1'b0, lf);
      repeat (5) @(negedge clk);
      chk("timing_counting", 0, int'(rt), 5);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs((where == 0) ? "rst_mid_hold" : "rst_mid_timing");
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] pred;
    rst_n   = 1'b0;
    tick    = 1'b0;
    trigger = 1'b0;
    react   = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Try to land the first hold on lfsr[2:0] == 5 (7 ticks); the model tracks it anyway.
    for (int w = 0; w < 200; w++) begin
      pred = adv(m_lfsr, 33);
      if (pred[2:0] == 3'd5) break;
      @(negedge clk);
    end

    seq(0, 37);
    seq(1, 0);
    seq(2, 0);
    seq(0, 1);
    reset_mid(0);
    reset_mid(1);
    seq(0, 20);

    repeat (4) @(negedge clk);
    chk("pending_events", 0, q0.size(), 0);
    chk("pending_events", 1, q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
